// File: rtl/datapath_pkg.sv
// Shared encodings for the parametrised bus datapath: bus source selects,
// CON condition codes and the memory handshake FSM states.
package datapath_pkg;

    localparam logic [3:0] SRC_REG    = 4'd0;
    localparam logic [3:0] SRC_HI     = 4'd1;
    localparam logic [3:0] SRC_LO     = 4'd2;
    localparam logic [3:0] SRC_ZHI    = 4'd3;
    localparam logic [3:0] SRC_ZLO    = 4'd4;
    localparam logic [3:0] SRC_PC     = 4'd5;
    localparam logic [3:0] SRC_MDR    = 4'd6;
    localparam logic [3:0] SRC_INPORT = 4'd7;
    localparam logic [3:0] SRC_C      = 4'd8;

    localparam logic [1:0] CON_EQZ = 2'd0;
    localparam logic [1:0] CON_NEZ = 2'd1;
    localparam logic [1:0] CON_GEZ = 2'd2;
    localparam logic [1:0] CON_LTZ = 2'd3;

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_if_fsm.sv
// Request/acknowledge memory handshake with a bounded wait and a sticky
// timeout flag; tells the datapath when MDR should capture read data.
module mem_if_fsm
    import datapath_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic mem_read,
    input  logic mem_write,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic mem_busy,
    output logic mem_err,
    output logic mdr_load
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             we_q;
    logic             start;
    logic             timeout;

    assign start    = mem_read | mem_write;
    assign mem_we   = we_q;
    assign mem_busy = (state == MEM_BUSY);

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mdr_load   = 1'b0;
        timeout    = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (start) next_state = MEM_BUSY;
            end
            MEM_BUSY: begin
                mem_req = 1'b1;
                // An ack on the final wait cycle still completes the access.
                if (mem_ack) begin
                    next_state = MEM_IDLE;
                    mdr_load   = ~we_q;
                end else if (wait_cnt == LAST) begin
                    next_state = MEM_IDLE;
                    timeout    = 1'b1;
                end
            end
            default: next_state = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= MEM_IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == MEM_IDLE && start) begin
                we_q     <= mem_write;
                wait_cnt <= '0;
            end else if (state == MEM_BUSY) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) mem_err <= 1'b1;
        end
    end

endmodule

// File: rtl/datapath_p.sv
// Single-bus CPU datapath: register file with IR-driven select/encode,
// special registers, I/O ports, CON flag and a handshaked memory interface.
module datapath_p
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [3:0]            bus_src,
    input  logic                  gra,
    input  logic                  grb,
    input  logic                  grc,
    input  logic                  rin,
    input  logic                  rout,
    input  logic                  ba_out,
    input  logic                  pc_in,
    input  logic                  inc_pc,
    input  logic                  ir_in,
    input  logic                  y_in,
    input  logic                  z_in,
    input  logic                  hi_in,
    input  logic                  lo_in,
    input  logic                  mar_in,
    input  logic                  mdr_in,
    input  logic                  out_in,
    input  logic                  in_strobe,
    input  logic                  con_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]     in_port_data,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     bus_data,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [4:0]            ir_opcode,
    output logic                  con_out,
    output logic [DATA_W-1:0]     out_port,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_busy,
    output logic                  mem_err
);

    localparam int unsigned RA_W  = $clog2(NREGS);
    localparam int unsigned RA_HI = DATA_W - 6;
    localparam int unsigned RB_HI = RA_HI - RA_W;
    localparam int unsigned RC_HI = RB_HI - RA_W;
    localparam int unsigned C_W   = DATA_W - 5 - 3 * RA_W;

    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   pc, ir, mar, mdr, hi, lo, y, in_port;
    logic [2*DATA_W-1:0] z;
    logic [RA_W-1:0]     ra, rb, rc, reg_idx;
    logic [1:0]          c2;
    logic [DATA_W-1:0]   c_ext;
    logic                con_next;
    logic                mdr_load;

    assign ra      = ir[RA_HI -: RA_W];
    assign rb      = ir[RB_HI -: RA_W];
    assign rc      = ir[RC_HI -: RA_W];
    assign c2      = rb[1:0];
    assign c_ext   = {{(DATA_W - C_W){ir[C_W-1]}}, ir[C_W-1:0]};
    assign reg_idx = ({RA_W{gra}} & ra) | ({RA_W{grb}} & rb) | ({RA_W{grc}} & rc);

    assign alu_a     = y;
    assign alu_b     = bus_data;
    assign ir_opcode = ir[DATA_W-1 -: 5];
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

    always_comb begin
        bus_data = '0;
        case (bus_src)
            SRC_REG: begin
                // ba_out turns R0 into a constant zero for base+offset addressing.
                if (rout && !(ba_out && reg_idx == '0)) bus_data = regs[reg_idx];
            end
            SRC_HI:     bus_data = hi;
            SRC_LO:     bus_data = lo;
            SRC_ZHI:    bus_data = z[2*DATA_W-1:DATA_W];
            SRC_ZLO:    bus_data = z[DATA_W-1:0];
            SRC_PC:     bus_data = pc;
            SRC_MDR:    bus_data = mdr;
            SRC_INPORT: bus_data = in_port;
            SRC_C:      bus_data = c_ext;
            default:    bus_data = '0;
        endcase
    end

    always_comb begin
        con_next = 1'b0;
        case (c2)
            CON_EQZ: con_next = (bus_data == '0);
            CON_NEZ: con_next = (bus_data != '0);
            CON_GEZ: con_next = ~bus_data[DATA_W-1];
            CON_LTZ: con_next = bus_data[DATA_W-1];
            default: con_next = 1'b0;
        endcase
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        always_ff @(posedge clk or posedge clr) begin
            if (clr)                                 regs[g] <= '0;
            else if (rin && reg_idx == RA_W'(g))     regs[g] <= bus_data;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            hi       <= '0;
            lo       <= '0;
            y        <= '0;
            z        <= '0;
            in_port  <= '0;
            out_port <= '0;
            con_out  <= 1'b0;
        end else begin
            if (pc_in)       pc <= bus_data;
            else if (inc_pc) pc <= pc + DATA_W'(1);
            if (ir_in)     ir       <= bus_data;
            if (mar_in)    mar      <= bus_data;
            if (hi_in)     hi       <= bus_data;
            if (lo_in)     lo       <= bus_data;
            if (y_in)      y        <= bus_data;
            if (z_in)      z        <= alu_result;
            if (in_strobe) in_port  <= in_port_data;
            if (out_in)    out_port <= bus_data;
            if (con_in)    con_out  <= con_next;
            // Completing read data takes priority over a bus load of MDR.
            if (mdr_load)    mdr <= mem_rdata;
            else if (mdr_in) mdr <= bus_data;
        end
    end

    mem_if_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_if (
        .clk      (clk),
        .clr      (clr),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_busy (mem_busy),
        .mem_err  (mem_err),
        .mdr_load (mdr_load)
    );

endmodule

// File: tb/tb_datapath_p.sv
// Scoreboard bench for datapath_p: stimulus queues expected values, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_datapath_p;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  bus_src;
  logic        gra, grb, grc, rin, rout, ba_out;
  logic        pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in;
  logic        mar_in, mdr_in, out_in, in_strobe, con_in;
  logic        mem_read, mem_write, mem_ack;
  logic [63:0] alu_result;
  logic [31:0] in_port_data, mem_rdata;

  logic [31:0] bus_data, alu_a, alu_b, out_port, mem_addr, mem_wdata;
  logic [4:0]  ir_opcode;
  logic        con_out, mem_req, mem_we, mem_busy, mem_err;

  logic [31:0] alu_result16;
  logic [15:0] in16, rdata16;
  logic [15:0] bus16, alu_a16, alu_b16, out16, addr16, wdata16;
  logic [4:0]  opc16;
  logic        con16, req16, we16, busy16, err16;

  always #5 clk = ~clk;

  datapath_p u_dut (
    .clk(clk), .clr(clr), .bus_src(bus_src),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
    .pc_in(pc_in), .inc_pc(inc_pc), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .out_in(out_in), .in_strobe(in_strobe), .con_in(con_in),
    .mem_read(mem_read), .mem_write(mem_write), .alu_result(alu_result),
    .in_port_data(in_port_data), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_data(bus_data), .alu_a(alu_a), .alu_b(alu_b), .ir_opcode(ir_opcode),
    .con_out(con_out), .out_port(out_port), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .mem_err(mem_err)
  );

  datapath_p #(.DATA_W(16), .NREGS(8), .TIMEOUT(15)) u_dut16 (
    .clk(clk), .clr(clr), .bus_src(bus_src),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
    .pc_in(pc_in), .inc_pc(inc_pc), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .hi_in(hi_in), .lo_in(lo_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .out_in(out_in), .in_strobe(in_strobe), .con_in(con_in),
    .mem_read(mem_read), .mem_write(mem_write), .alu_result(alu_result16),
    .in_port_data(in16), .mem_ack(mem_ack), .mem_rdata(rdata16),
    .bus_data(bus16), .alu_a(alu_a16), .alu_b(alu_b16), .ir_opcode(opc16),
    .con_out(con16), .out_port(out16), .mem_req(req16), .mem_we(we16),
    .mem_addr(addr16), .mem_wdata(wdata16), .mem_busy(busy16),
    .mem_err(err16)
  );

  typedef enum int {
    S_BUS, S_ALUA, S_OPC, S_CON, S_OUT, S_REQ, S_WE, S_ADDR, S_WDATA,
    S_BUSY, S_ERR, S_BUS16, S_REQ16
  } sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [63:0] act;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [63:0] observe(input sig_e s);
    case (s)
      S_BUS:   return {32'b0, bus_data};
      S_ALUA:  return {32'b0, alu_a};
      S_OPC:   return {59'b0, ir_opcode};
      S_CON:   return {63'b0, con_out};
      S_OUT:   return {32'b0, out_port};
      S_REQ:   return {63'b0, mem_req};
      S_WE:    return {63'b0, mem_we};
      S_ADDR:  return {32'b0, mem_addr};
      S_WDATA: return {32'b0, mem_wdata};
      S_BUSY:  return {63'b0, mem_busy};
      S_ERR:   return {63'b0, mem_err};
      S_BUS16: return {48'b0, bus16};
      S_REQ16: return {63'b0, req16};
      default: return '1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = observe(cur.sig);
      checks++;
      if (act !== cur.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input sig_e s, input logic [63:0] v);
    sb.push_back('{n, s, v});
  endtask

  task automatic check_now(input string n, input sig_e s, input logic [63:0] v);
    logic [63:0] got;
    got = observe(s);
    checks++;
    if (got !== v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, got, v);
    end
  endtask

  task automatic inport(input logic [31:0] v);
    in_port_data = v;
    in_strobe    = 1'b1;
    cyc();
    in_strobe = 1'b0;
    bus_src   = SRC_INPORT;
  endtask

  task automatic load_ir(input logic [31:0] v);
    inport(v);
    ir_in = 1'b1;
    cyc();
    ir_in = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    bus_src = '0;
    {gra, grb, grc, rin, rout, ba_out} = '0;
    {pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in} = '0;
    {mar_in, mdr_in, out_in, in_strobe, con_in} = '0;
    {mem_read, mem_write, mem_ack} = '0;
    alu_result = '0; in_port_data = '0; mem_rdata = '0;
    alu_result16 = '0; in16 = '0; rdata16 = '0;
    cyc();
    check_now("rst_now_bus", S_BUS, 0);
    check_now("rst_now_err", S_ERR, 0);
    check_now("rst_now_busy", S_BUSY, 0);
    chk("rst_bus", S_BUS, 0);     chk("rst_alua", S_ALUA, 0);
    chk("rst_opc", S_OPC, 0);     chk("rst_con", S_CON, 0);
    chk("rst_out", S_OUT, 0);     chk("rst_req", S_REQ, 0);
    chk("rst_we", S_WE, 0);       chk("rst_addr", S_ADDR, 0);
    chk("rst_wdata", S_WDATA, 0); chk("rst_busy", S_BUSY, 0);
    chk("rst_err", S_ERR, 0);     chk("rst_bus16", S_BUS16, 0);
    cyc();
    clr = 1'b0;

    // IR load, register select/encode, ba_out
    inport(32'h0A98_0000);
    ir_in = 1'b1;
    chk("bus_inport", S_BUS, 32'h0A98_0000);
    cyc();
    ir_in = 1'b0;
    chk("ir_opcode", S_OPC, 1);
    inport(32'h1234);
    gra = 1'b1; rin = 1'b1;
    cyc();
    rin = 1'b0; bus_src = SRC_REG; rout = 1'b1;
    chk("r5_read", S_BUS, 32'h1234);
    cyc();
    gra = 1'b0; rout = 1'b0;
    inport(32'h55);
    grc = 1'b1; rin = 1'b1;
    cyc();
    rin = 1'b0; bus_src = SRC_REG; rout = 1'b1;
    chk("r0_read", S_BUS, 32'h55);
    cyc();
    ba_out = 1'b1;
    chk("ba_out_r0", S_BUS, 0);
    cyc();
    grc = 1'b0; gra = 1'b1;
    chk("ba_out_r5", S_BUS, 32'h1234);
    cyc();
    gra = 1'b0; ba_out = 1'b0; rout = 1'b0;

    // Y, OUTPORT, HI, LO, Z halves, unused source, C sign extension
    inport(32'hA5A5_0001);
    y_in = 1'b1; out_in = 1'b1; hi_in = 1'b1;
    cyc();
    y_in = 1'b0; out_in = 1'b0; hi_in = 1'b0;
    chk("alu_a", S_ALUA, 32'hA5A5_0001);
    chk("out_port", S_OUT, 32'hA5A5_0001);
    bus_src = SRC_HI;
    chk("bus_hi", S_BUS, 32'hA5A5_0001);
    cyc();
    inport(32'h0F0F);
    lo_in = 1'b1;
    cyc();
    lo_in = 1'b0; bus_src = SRC_LO;
    alu_result = 64'h1122_3344_5566_7788; z_in = 1'b1;
    chk("bus_lo", S_BUS, 32'h0F0F);
    cyc();
    z_in = 1'b0; bus_src = SRC_ZHI;
    chk("bus_zhi", S_BUS, 32'h1122_3344);
    cyc();
    bus_src = SRC_ZLO;
    chk("bus_zlo", S_BUS, 32'h5566_7788);
    cyc();
    bus_src = 4'd9;
    chk("bus_src9", S_BUS, 0);
    cyc();
    load_ir(32'h0000_4000);
    bus_src = SRC_C;
    chk("c_sext_neg", S_BUS, 32'hFFFF_C000);
    cyc();
    load_ir(32'h0000_3FFF);
    bus_src = SRC_C;
    chk("c_sext_pos", S_BUS, 32'h0000_3FFF);
    cyc();

    // Read with 3-cycle latency
    inport(32'h40);
    mar_in = 1'b1;
    cyc();
    mar_in = 1'b0;
    chk("mar_addr", S_ADDR, 32'h40);
    chk("idle_busy", S_BUSY, 0);
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    chk("rd_req1", S_REQ, 1); chk("rd_busy1", S_BUSY, 1); chk("rd_we", S_WE, 0);
    cyc();
    chk("rd_busy2", S_BUSY, 1);
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("rd_busy3", S_BUSY, 1);
    cyc();
    mem_ack = 1'b0;
    chk("rd_req_done", S_REQ, 0); chk("rd_busy_done", S_BUSY, 0);
    chk("rd_mdr", S_WDATA, 32'hDEAD_BEEF);
    bus_src = SRC_MDR;
    chk("bus_mdr", S_BUS, 32'hDEAD_BEEF);
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'h1111;
    cyc();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", S_WDATA, 32'hDEAD_BEEF);

    // Timeout; a read pulse mid-wait must not restart the wait
    mem_read = 1'b1;
    cyc();
    for (int i = 0; i < 15; i++) begin
      mem_read = (i == 5);
      chk($sformatf("to_req_%0d", i), S_REQ, 1);
      cyc();
    end
    mem_read = 1'b0;
    check_now("to_now_err", S_ERR, 1);
    check_now("to_now_req", S_REQ, 0);
    check_now("to_now_busy", S_BUSY, 0);
    check_now("to_now_mdr", S_WDATA, 32'hDEAD_BEEF);
    chk("to_req_end", S_REQ, 0); chk("to_err", S_ERR, 1);
    chk("to_busy", S_BUSY, 0);   chk("to_mdr_kept", S_WDATA, 32'hDEAD_BEEF);
    cyc();

    // Second read with mdr_in in the ack cycle
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0; bus_src = SRC_INPORT; mdr_in = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    chk("rd2_req", S_REQ, 1);
    cyc();
    mdr_in = 1'b0; mem_ack = 1'b0;
    chk("rd2_mdr_wins", S_WDATA, 32'hCAFE_F00D);
    chk("rd2_err_sticky", S_ERR, 1); chk("rd2_busy", S_BUSY, 0);
    mdr_in = 1'b1;
    cyc();
    mdr_in = 1'b0;
    chk("mdr_in_load", S_WDATA, 32'h40);
    mem_write = 1'b1; mem_read = 1'b1;
    cyc();
    mem_write = 1'b0; mem_read = 1'b0;
    chk("wr_we", S_WE, 1); chk("wr_req", S_REQ, 1);
    mem_ack = 1'b1; mem_rdata = 32'h9999;
    cyc();
    mem_ack = 1'b0;
    chk("wr_busy_done", S_BUSY, 0); chk("wr_mdr_kept", S_WDATA, 32'h40);

    // PC priority and wrap
    inport(32'h100);
    pc_in = 1'b1; inc_pc = 1'b1;
    cyc();
    pc_in = 1'b0; bus_src = SRC_PC;
    chk("pc_in_wins", S_BUS, 32'h100);
    cyc();
    inc_pc = 1'b0;
    chk("pc_inc", S_BUS, 32'h101);
    inport(32'hFFFF_FFFF);
    pc_in = 1'b1;
    cyc();
    pc_in = 1'b0; inc_pc = 1'b1; bus_src = SRC_PC;
    chk("pc_max", S_BUS, 32'hFFFF_FFFF);
    cyc();
    inc_pc = 1'b0;
    chk("pc_wrap", S_BUS, 0);

    // CON conditions: C2 = 11, 00, 10, 01
    load_ir(32'h0A98_0000);
    inport(32'h8000_0000);
    con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    chk("con_ltz", S_CON, 1);
    load_ir(32'h0A80_0000);
    inport(32'h5);
    con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    chk("con_eqz", S_CON, 0);
    load_ir(32'h0A90_0000);
    inport(32'h8000_0000);
    con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    chk("con_gez", S_CON, 0);
    load_ir(32'h0A88_0000);
    inport(32'h5);
    con_in = 1'b1;
    cyc();
    con_in = 1'b0;
    chk("con_nez", S_CON, 1);
    cyc();

    // Asynchronous reset in the middle of a read
    bus_src = SRC_REG; rout = 1'b0;
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    chk("pre_clr_req", S_REQ, 1); chk("pre_clr_req16", S_REQ16, 1);
    cyc();
    clr = 1'b1;
    #1;
    chk("clr_req", S_REQ, 0);     chk("clr_busy", S_BUSY, 0);
    chk("clr_err", S_ERR, 0);     chk("clr_bus", S_BUS, 0);
    chk("clr_alua", S_ALUA, 0);   chk("clr_out", S_OUT, 0);
    chk("clr_addr", S_ADDR, 0);   chk("clr_wdata", S_WDATA, 0);
    chk("clr_con", S_CON, 0);     chk("clr_opc", S_OPC, 0);
    chk("clr_req16", S_REQ16, 0); chk("clr_bus16", S_BUS16, 0);
    cyc();
    clr = 1'b0; rout = 1'b1;
    chk("clr_r0", S_BUS, 0);
    cyc();
    rout = 1'b0;

    // 16-bit / 8-register instance: C is the 2 low IR bits, sign-extended
    in16 = 16'h001F; in_strobe = 1'b1;
    cyc();
    in_strobe = 1'b0; bus_src = SRC_INPORT; ir_in = 1'b1;
    cyc();
    ir_in = 1'b0; bus_src = SRC_C;
    chk("c16_neg", S_BUS16, 16'hFFFF);
    cyc();
    in16 = 16'h0001; in_strobe = 1'b1;
    cyc();
    in_strobe = 1'b0; bus_src = SRC_INPORT; ir_in = 1'b1;
    cyc();
    ir_in = 1'b0; bus_src = SRC_C;
    chk("c16_pos", S_BUS16, 16'h0001);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
